// File: rtl/aes_key_expander.sv
`default_nettype none
// ============================================================================
// aes_key_expander : AES-128/256 key schedule into a 15 x 128 round-key memory
// Define AES_KEY_EXPANDER_ZEROIZE_EN to add a synchronous zeroize input.
// Revision 1.0
// ============================================================================
module aes_key_expander (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [255:0] key,
   input  logic         keylen,
   input  logic         init,
   input  logic [3:0]   round,
   output logic [127:0] round_key,
   output logic         ready,
   output logic [31:0]  sboxw,
   input  logic [31:0]  new_sboxw
`ifdef AES_KEY_EXPANDER_ZEROIZE_EN
   ,
   input  logic         zeroize
`endif
);

   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_INIT     = 2'd1;
   localparam logic [1:0] c_GENERATE = 2'd2;
   localparam logic [1:0] c_DONE     = 2'd3;

   logic [1:0]   r_state;
   logic [1:0]   w_next_state;
   logic [3:0]   r_ctr;
   logic [7:0]   r_rcon;
   logic [7:0]   w_rcon_next;
   logic [127:0] r_prev0;
   logic [127:0] r_prev1;
   logic [127:0] r_mem [0:14];
   logic         r_ready;
   logic         w_zeroize;
   logic         w_last;
   logic         w_use_rcon;
   logic [3:0]   w_num_rounds;
   logic [31:0]  w_t;
   logic [31:0]  w_w0;
   logic [31:0]  w_w1;
   logic [31:0]  w_w2;
   logic [31:0]  w_w3;
   logic [127:0] w_new_key;

`ifdef AES_KEY_EXPANDER_ZEROIZE_EN
   assign w_zeroize = zeroize;
`else
   assign w_zeroize = 1'b0;
`endif

   // ">=" rather than "==" keeps the FSM terminating if keylen drops mid-run
   assign w_num_rounds = keylen ? 4'd14 : 4'd10;
   assign w_last       = (r_ctr >= w_num_rounds);
   assign w_rcon_next  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

   // rcon is consumed every AES-128 round >= 1 and every even AES-256 round >= 2
   assign w_use_rcon = (r_state == c_GENERATE) && (r_ctr != 4'd0) && (!keylen || !r_ctr[0]);
   assign w_t        = new_sboxw ^ {(w_use_rcon ? w_rcon_next : 8'h00), 24'h0};

   assign w_w0 = r_prev0[127:96] ^ w_t;
   assign w_w1 = r_prev0[95:64]  ^ w_w0;
   assign w_w2 = r_prev0[63:32]  ^ w_w1;
   assign w_w3 = r_prev0[31:0]   ^ w_w2;

   assign ready     = r_ready;
   assign round_key = (round == 4'd15) ? 128'h0 : r_mem[round];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:     if (init) w_next_state = c_INIT;
         c_INIT:     w_next_state = c_GENERATE;
         c_GENERATE: if (w_last) w_next_state = c_DONE;
         default:    w_next_state = c_IDLE;
      endcase
      if (w_zeroize) begin
         w_next_state = c_IDLE;
      end
   end

   always_comb begin
      sboxw = 32'h0;
      if (r_state == c_GENERATE && r_ctr != 4'd0 && !(keylen && r_ctr == 4'd1)) begin
         if (!keylen) begin
            sboxw = {r_prev0[23:0], r_prev0[31:24]};
         end else if (!r_ctr[0]) begin
            sboxw = {r_prev1[23:0], r_prev1[31:24]};
         end else begin
            sboxw = r_prev1[31:0];
         end
      end
   end

   always_comb begin
      w_new_key = {w_w0, w_w1, w_w2, w_w3};
      if (r_ctr == 4'd0) begin
         w_new_key = key[255:128];
      end else if (keylen && r_ctr == 4'd1) begin
         w_new_key = key[127:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ready <= 1'b1;
         r_ctr   <= 4'd0;
         r_rcon  <= 8'h8d;
         r_prev0 <= 128'h0;
         r_prev1 <= 128'h0;
         for (int i = 0; i < 15; i++) begin
            r_mem[i] <= 128'h0;
         end
      end else if (w_zeroize) begin
         r_ready <= 1'b1;
         r_ctr   <= 4'd0;
         r_rcon  <= 8'h8d;
         r_prev0 <= 128'h0;
         r_prev1 <= 128'h0;
         for (int i = 0; i < 15; i++) begin
            r_mem[i] <= 128'h0;
         end
      end else begin
         case (r_state)
            c_IDLE: begin
               if (init) r_ready <= 1'b0;
            end
            c_INIT: begin
               r_ctr  <= 4'd0;
               r_rcon <= 8'h8d;
            end
            c_GENERATE: begin
               r_mem[r_ctr] <= w_new_key;
               r_ctr        <= r_ctr + 4'd1;
               if (w_use_rcon) r_rcon <= w_rcon_next;
               if (r_ctr == 4'd0) begin
                  r_prev0 <= key[255:128];
                  r_prev1 <= key[127:0];
               end else if (!keylen) begin
                  r_prev0 <= w_new_key;
               end else if (r_ctr != 4'd1) begin
                  r_prev0 <= r_prev1;
                  r_prev1 <= w_new_key;
               end
            end
            default: begin
               r_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// Testbench for aes_key_expander: random and known-answer expansions scored
// against a word-level FIPS-197 key-schedule model through a scoreboard queue.
module tb_aes_key_expander;

   typedef logic [14:0][127:0] mem_t;
   typedef logic [19:0][31:0]  sbx_t;
   localparam int K_EXPAND = 0;
   localparam int K_CHECK  = 1;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [255:0] key;
   logic         keylen;
   logic         init;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic         ready;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;
`ifdef AES_KEY_EXPANDER_ZEROIZE_EN
   logic         zeroize;
`endif

   logic [7:0] sbox [256];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   mem_t model_mem;
   bit   active = 1'b0;

   int   q_kind[$];
   int   q_start[$];
   int   q_lat[$];
   int   q_kat[$];
   mem_t q_mem[$];
   sbx_t q_sb[$];

   aes_key_expander dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .key       (key),
      .keylen    (keylen),
      .init      (init),
      .round     (round),
      .round_key (round_key),
      .ready     (ready),
      .sboxw     (sboxw),
      .new_sboxw (new_sboxw)
`ifdef AES_KEY_EXPANDER_ZEROIZE_EN
      ,
      .zeroize   (zeroize)
`endif
   );

   always #40 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign new_sboxw = {sbox[sboxw[31:24]], sbox[sboxw[23:16]], sbox[sboxw[15:8]], sbox[sboxw[7:0]]};

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [31:0] rotw(input logic [31:0] x);
      return {x[23:0], x[31:24]};
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // FIPS-197 KeyExpansion over a flat word array; also records the word each
   // round hands to SubWord, indexed by cycles after the init-sampling edge.
   task automatic model_run(input logic [255:0] k, input logic kl, output sbx_t sb);
      logic [31:0] w [60];
      logic [31:0] tmp;
      logic [7:0]  rc;
      int nk;
      int nr;
      nk = kl ? 8 : 4;
      nr = kl ? 14 : 10;
      rc = 8'h01;
      sb = '0;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            sb[i/4 + 1] = rotw(tmp);
            tmp = subw(rotw(tmp)) ^ {rc, 24'h0};
            rc  = xtime(rc);
         end else if (nk == 8 && i % nk == 4) begin
            sb[i/4 + 1] = tmp;
            tmp = subw(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int r = 0; r <= nr; r++) model_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic sweep(input mem_t m);
      for (int r = 0; r < 16; r++) begin
         round = 4'(r);
         #1;
         if (r == 15) chk("round_key[15]", round_key, 128'h0);
         else         chk($sformatf("round_key[%0d]", r), round_key, m[r]);
      end
   endtask

   task automatic kat_check(input int which);
      if (which == 1) begin
         round = 4'd0;  #1; chk("kat128_r0",  round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
         round = 4'd1;  #1; chk("kat128_r1",  round_key, 128'ha0fafe1788542cb123a339392a6c7605);
         round = 4'd10; #1; chk("kat128_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      end else if (which == 2) begin
         round = 4'd0;  #1; chk("kat256_r0",  round_key, 128'h603deb1015ca71be2b73aef0857d7781);
         round = 4'd1;  #1; chk("kat256_r1",  round_key, 128'h1f352c073b6108d72d9810a30914dff4);
         round = 4'd2;  #1; chk("kat256_r2",  round_key, 128'h9ba354118e6925afa51a8b5f2067fcde);
         round = 4'd14; #1; chk("kat256_r14", round_key, 128'hfe4890d1e6188d0b046df344706c631e);
      end
   endtask

   // Monitor: pops an expected expansion when ready falls, checks the S-box
   // request trace each cycle, then the latency and memory when ready returns.
   initial begin : monitor
      int   off;
      int   cur_start;
      int   cur_lat;
      int   cur_kat;
      int   cur_kind;
      mem_t cur_mem;
      sbx_t cur_sb;
      round = 4'd0;
      forever begin
         @(posedge clk);
         #1;
         if (!active) begin
            if (q_kind.size() > 0 && (q_kind[0] == K_CHECK || !ready)) begin
               cur_kind  = q_kind.pop_front();
               cur_start = q_start.pop_front();
               cur_lat   = q_lat.pop_front();
               cur_kat   = q_kat.pop_front();
               cur_mem   = q_mem.pop_front();
               cur_sb    = q_sb.pop_front();
               if (cur_kind == K_CHECK) begin
                  chk("ready_idle", {127'h0, ready}, 128'h1);
                  sweep(cur_mem);
               end else begin
                  active = 1'b1;
                  chk("ready_fall_edge", 128'(cyc), 128'(cur_start));
               end
            end else if (ready) begin
               chk("sboxw_idle", {96'h0, sboxw}, 128'h0);
            end
         end
         if (active) begin
            off = cyc - cur_start;
            if (ready) begin
               chk("ready_latency", 128'(off), 128'(cur_lat));
               sweep(cur_mem);
               kat_check(cur_kat);
               active = 1'b0;
            end else if (off > 40) begin
               n_vec++;
               n_bad++;
               $display("FAIL monitor_timeout: ready still low %0d edges after init, required %0d", off, cur_lat);
               active = 1'b0;
            end else if (off >= 0 && off < 20) begin
               chk($sformatf("sboxw_trace[%0d]", off), {96'h0, sboxw}, {96'h0, cur_sb[off]});
            end
         end
      end
   end

   task automatic start_exp(input logic [255:0] k, input logic kl, input int kat, input bit abort, input bit hold);
      sbx_t sb;
      key    = k;
      keylen = kl;
      model_run(k, kl, sb);
      if (abort) model_mem = '0;
      init = 1'b1;
      q_start.push_back(cyc + 1);
      q_lat.push_back(abort ? 6 : (kl ? 17 : 13));
      q_kat.push_back(kat);
      q_mem.push_back(model_mem);
      q_sb.push_back(sb);
      q_kind.push_back(K_EXPAND);
      @(negedge clk);
      if (!hold) init = 1'b0;
   endtask

   task automatic push_check();
      q_start.push_back(0);
      q_lat.push_back(0);
      q_kat.push_back(0);
      q_mem.push_back(model_mem);
      q_sb.push_back('0);
      q_kind.push_back(K_CHECK);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         if (q_kind.size() == 0 && !active) return;
         @(negedge clk);
      end
      n_vec++;
      n_bad++;
      $display("FAIL wait_idle: %0d expected responses never observed, required 0", q_kind.size());
      q_kind.delete(); q_start.delete(); q_lat.delete();
      q_kat.delete();  q_mem.delete();   q_sb.delete();
   endtask

   function automatic logic [255:0] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin : driver
      logic [7:0] inv;
      logic [255:0] kat128;
      logic [255:0] kat256;
      for (int i = 0; i < 256; i++) begin
         inv = 8'h00;
         for (int x = 1; x < 256; x++) begin
            if (gmul(8'(i), 8'(x)) == 8'h01) inv = 8'(x);
         end
         sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      kat128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 96'h0, $urandom()};
      kat256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      reset_n   = 1'b0;
      key       = '0;
      keylen    = 1'b0;
      init      = 1'b0;
      model_mem = '0;
`ifdef AES_KEY_EXPANDER_ZEROIZE_EN
      zeroize   = 1'b0;
`endif
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      push_check();
      wait_idle();

      start_exp(kat128, 1'b0, 1, 1'b0, 1'b0);
      wait_idle();
      start_exp(kat256, 1'b1, 2, 1'b0, 1'b0);
      wait_idle();

      // init held high, dropped and re-raised mid-GENERATE: must not restart
      start_exp(kat128, 1'b0, 1, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      init = 1'b0;
      @(negedge clk);
      init = 1'b1;
      for (int i = 0; i < 40 && !ready; i++) @(negedge clk);
      init = 1'b0;
      wait_idle();

      // reset mid AES-256 expansion, then a fresh AES-128 run
      start_exp(rand_key(), 1'b1, 0, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      wait_idle();
      start_exp(kat128, 1'b0, 1, 1'b0, 1'b0);
      wait_idle();

      for (int i = 0; i < 8; i++) begin
         start_exp(rand_key(), 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
         wait_idle();
      end

`ifdef AES_KEY_EXPANDER_ZEROIZE_EN
      start_exp(rand_key(), 1'b1, 0, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      wait_idle();
      start_exp(kat256, 1'b1, 2, 1'b0, 1'b0);
      wait_idle();
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      model_mem = '0;
      push_check();
      wait_idle();
`endif

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
